simple_pipe_chain: RTL and testbench
====================================

SIMPLE_PIPE_CHAIN -- requirements
Module: simple_pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per lane, legal range >= 1.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages, legal range >= 1.
REQ-003 SHALL have parameter INVERT, default 1: output polarity; 1 = out is the bitwise inverse of stage data.
REQ-004 SHALL have port tau2015_clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-005 SHALL have port tau2015_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port inp1, input, WIDTH bits: operand A.
REQ-007 SHALL have port inp2, input, WIDTH bits: operand B.
REQ-008 SHALL have port in_valid, input, 1 bit: inp1/inp2 beat offered.
REQ-009 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid & in_ready.
REQ-010 SHALL have port out, output, WIDTH bits: result data.
REQ-011 SHALL have port out_valid, output, 1 bit: out holds a beat.
REQ-012 SHALL have port out_ready, input, 1 bit: beat consumed when out_valid & out_ready.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH+1) bits: number of valid stages.
REQ-014 SHALL have port stat_beats, output, 16 bits: output transfer count (see Configuration).

Function
REQ-015 SHALL hold a WIDTH-bit front register F; on each accepted beat, next value N = (inp1 & inp2) & ~F, F <= N, and N enters stage 0.
REQ-016 SHALL leave F unchanged on cycles with no accepted beat.
REQ-017 SHALL implement DEPTH elastic stages, each holding valid + data; stage k advances when stage k+1 is empty or advancing; the last stage advances on out_ready.
REQ-018 SHALL collapse bubbles: a beat moves forward whenever the next stage is free, regardless of downstream stalls further on.
REQ-019 SHALL drive in_ready = stage 0 empty OR stage 0 advancing this cycle; in_ready is combinational from out_ready through the stage chain.
REQ-020 SHALL drive out = last-stage data XOR {WIDTH{INVERT}}, and out_valid = last-stage valid.
REQ-021 SHALL have a latency of exactly DEPTH cycles from acceptance to out_valid in an unstalled pipe, with throughput 1 beat/cycle.
REQ-022 SHALL hold out and out_valid stable while out_valid & ~out_ready.
REQ-023 SHALL preserve order, with no loss or duplication, under any out_ready pattern.
REQ-024 SHALL update occupancy each cycle as +1 on acceptance and -1 on consumption; simultaneous acceptance and consumption leaves it unchanged; maximum value DEPTH.
REQ-025 SHALL accept a beat on a full pipe when out_ready=1 in the same cycle.

Reset
REQ-026 SHALL, while tau2015_rst_n=0 (asynchronous, at any point including mid-stream), clear F, all stage valids, all stage data and occupancy to 0.
REQ-027 SHALL produce reset output values out = {WIDTH{INVERT}}, out_valid=0, in_ready=1, occupancy=0 and stat_beats=0.
REQ-028 SHALL discard beats in flight at reset; the first post-reset beat SHALL use F=0.

Configuration
REQ-029 SHALL, with SIMPLE_PIPE_CHAIN_STATS_EN defined, increment stat_beats on each output transfer, saturating at 16'hFFFF.
REQ-030 SHALL, without SIMPLE_PIPE_CHAIN_STATS_EN, keep the stat_beats port present and tie it to 0, with no counter flops.

Structure
REQ-031 SHALL place in package simple_pipe_chain_pkg the constant STAT_W=16, the default parameter constants, and the occupancy-width helper function.
REQ-032 SHALL implement one stage as sub-module simple_pipe_stage (valid/data register plus advance logic), instantiated DEPTH times via generate.

Verification (WIDTH=8, DEPTH=4, INVERT=1)
REQ-033 SHALL cover reset: rst_n pulsed low mid-stream -> same cycle: out_valid=0, occupancy=0, out=8'hFF, in_ready=1.
REQ-034 SHALL cover streaming: inp1=8'hF0, inp2=8'h3C, in_valid=1, out_ready=1 -> first out_valid 4 cycles after first accept; out alternates 8'hCF, 8'hFF, 8'hCF...
REQ-035 SHALL cover backpressure: out_ready=0, 4 beats accepted -> in_ready=0, occupancy=4, 5th beat held; release -> all beats in order, none lost or duplicated.
REQ-036 SHALL cover full plus simultaneous pop: full pipe, in_valid=1, out_ready=1 -> in_ready=1, occupancy stays 4.
REQ-037 SHALL cover a single beat into an empty pipe: out_valid exactly 4 cycles later, occupancy=1 throughout, then 0.
REQ-038 SHALL cover statistics: 70000 transfers with the macro -> stat_beats=16'hFFFF; without the macro -> stat_beats=0.

Source files
------------

// File: rtl/simple_pipe_chain_pkg.sv
// rtl/simple_pipe_chain_pkg.sv - shared constants and helpers for the elastic pipe chain
package simple_pipe_chain_pkg;

    localparam int STAT_W     = 16;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_INVERT = 1;

    // Bits needed to count 0..depth valid stages
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/simple_pipe_stage.sv
// rtl/simple_pipe_stage.sv - one elastic valid/data register stage with advance logic
module simple_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_free,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    // Free when empty or when the held beat leaves this cycle; this is what collapses bubbles
    assign free = ~valid | down_free;

    // Load from upstream whenever free; otherwise hold the stalled beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (free) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/simple_pipe_chain.sv
// rtl/simple_pipe_chain.sv - front register feeding DEPTH elastic stages; stats counter under SIMPLE_PIPE_CHAIN_STATS_EN
module simple_pipe_chain
    import simple_pipe_chain_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int INVERT = DEF_INVERT
) (
    input  logic                         tau2015_clk,
    input  logic                         tau2015_rst_n,
    input  logic [WIDTH-1:0]             inp1,
    input  logic [WIDTH-1:0]             inp2,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    output logic [STAT_W-1:0]            stat_beats
);

    localparam int   OCC_W   = occ_width(DEPTH);
    localparam logic INV_BIT = (INVERT != 0);

    logic [WIDTH-1:0] front;
    logic [WIDTH-1:0] front_next;
    logic             accept;
    logic             consume;
    logic [OCC_W-1:0] occ;

    logic             up_valid    [DEPTH];
    logic [WIDTH-1:0] up_data     [DEPTH];
    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_free  [DEPTH+1];

    // The free chain ripples back from out_ready, so in_ready is combinational on it
    assign stage_free[DEPTH] = out_ready;
    assign in_ready          = stage_free[0];
    assign accept            = in_valid & in_ready;
    assign consume           = stage_valid[DEPTH-1] & out_ready;
    assign front_next        = (inp1 & inp2) & ~front;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_valid[k] = in_valid;
            assign up_data[k]  = front_next;
        end else begin : g_link
            assign up_valid[k] = stage_valid[k-1];
            assign up_data[k]  = stage_data[k-1];
        end

        simple_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (tau2015_clk),
            .rst_n     (tau2015_rst_n),
            .up_valid  (up_valid[k]),
            .up_data   (up_data[k]),
            .down_free (stage_free[k+1]),
            .valid     (stage_valid[k]),
            .data      (stage_data[k]),
            .free      (stage_free[k])
        );
    end

    // Front register only moves on accepted beats, so idle cycles keep the mask
    always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
        if (!tau2015_rst_n) begin
            front <= '0;
        end else if (accept) begin
            front <= front_next;
        end
    end

    // Occupancy tracks accepted minus consumed beats
    always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
        if (!tau2015_rst_n) begin
            occ <= '0;
        end else begin
            case ({accept, consume})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign occupancy = occ;
    assign out       = stage_data[DEPTH-1] ^ {WIDTH{INV_BIT}};
    assign out_valid = stage_valid[DEPTH-1];

`ifdef SIMPLE_PIPE_CHAIN_STATS_EN
    logic [STAT_W-1:0] beats;

    // Saturating count of output transfers
    always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
        if (!tau2015_rst_n) begin
            beats <= '0;
        end else if (consume && (beats != {STAT_W{1'b1}})) begin
            beats <= beats + 1'b1;
        end
    end

    assign stat_beats = beats;
`else
    assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_simple_pipe_chain.sv
// tb/tb_simple_pipe_chain.sv - self-checking bench for simple_pipe_chain with a queue-based reference model
module tb_simple_pipe_chain;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] inp1;
    logic [W-1:0] inp2;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   occupancy;
    logic [15:0]  stat_beats;

    simple_pipe_chain #(.WIDTH(W), .DEPTH(D), .INVERT(1)) dut (
        .tau2015_clk   (clk),
        .tau2015_rst_n (rst_n),
        .inp1          (inp1),
        .inp2          (inp2),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out           (out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .occupancy     (occupancy),
        .stat_beats    (stat_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           t;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] m_front;
    int           cyc;
    int           m_stat;
    int           vectors;
    int           miscompares;

    function automatic logic m_out_valid();
        return (q.size() > 0) && (cyc >= q[0].t + D - 1);
    endfunction

    function automatic logic m_in_ready();
        return (q.size() < D) || out_ready;
    endfunction

    // Reference model: a beat is visible at the output D-1 edges after its acceptance edge, unless blocked behind the head
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_front = '0;
            m_stat  = 0;
        end else begin
            logic  acc;
            logic  con;
            beat_t b;
            con = m_out_valid() && out_ready;
            acc = in_valid && m_in_ready();
            if (con) begin
                void'(q.pop_front());
                if (m_stat < 16'hFFFF) m_stat++;
            end
            cyc++;
            if (acc) begin
                b.d     = (inp1 & inp2) & ~m_front;
                b.t     = cyc;
                m_front = b.d;
                q.push_back(b);
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [15:0] exp_stat;
`ifdef SIMPLE_PIPE_CHAIN_STATS_EN
        exp_stat = 16'(m_stat);
`else
        exp_stat = 16'h0;
`endif
        cmp("out_valid", {31'b0, out_valid}, {31'b0, m_out_valid()});
        cmp("occupancy", {29'b0, occupancy}, q.size());
        cmp("in_ready", {31'b0, in_ready}, {31'b0, m_in_ready()});
        cmp("stat_beats", {16'b0, stat_beats}, {16'b0, exp_stat});
        if (m_out_valid()) cmp("out_data", {24'b0, out}, {24'b0, q[0].d ^ 8'hFF});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0) && (n < budget)) begin
            step();
            n++;
        end
        cmp("drain_done", q.size(), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        inp1        = '0;
        inp2        = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        #1;
        cmp("rst_out", {24'b0, out}, 32'hFF);
        cmp("rst_in_ready", {31'b0, in_ready}, 1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Streaming F0 & 3C: alternates N=30 / 0, so out is CF, FF, CF ...
        inp1 = 8'hF0; inp2 = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        step();
        step();
        step();
        cmp("lat_not_yet", {31'b0, out_valid}, 0);
        step();
        cmp("lat_first", {31'b0, out_valid}, 1);
        cmp("stream_0", {24'b0, out}, 32'hCF);
        step();
        cmp("stream_1", {24'b0, out}, 32'hFF);
        step();
        cmp("stream_2", {24'b0, out}, 32'hCF);

        // Asynchronous reset mid-stream, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        cmp("mid_rst_valid", {31'b0, out_valid}, 0);
        cmp("mid_rst_occ", {29'b0, occupancy}, 0);
        cmp("mid_rst_out", {24'b0, out}, 32'hFF);
        cmp("mid_rst_ready", {31'b0, in_ready}, 1);
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();

        // Backpressure with distinct beats; 5th beat must be held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inp2      = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            inp1 = 8'(8'h11 * (i + 1));
            step();
        end
        cmp("bp_occ", {29'b0, occupancy}, 4);
        cmp("bp_in_ready", {31'b0, in_ready}, 0);
        cmp("bp_first", {24'b0, out}, 32'hEE);

        // Full pipe plus simultaneous pop
        out_ready = 1'b1;
        #1;
        cmp("full_pop_ready", {31'b0, in_ready}, 1);
        step();
        cmp("full_pop_occ", {29'b0, occupancy}, 4);

        // Irregular release pattern exercises order under stalls
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 3) != 1;
            step();
        end
        drain(40);

        // Single beat into an empty pipe
        inp1 = 8'h5A; inp2 = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cmp("single_occ", {29'b0, occupancy}, 1);
            cmp("single_valid", {31'b0, out_valid}, (k == 4) ? 1 : 0);
            if (k < 4) step();
        end
        step();
        cmp("single_occ_end", {29'b0, occupancy}, 0);

`ifdef SIMPLE_PIPE_CHAIN_STATS_EN
        inp1 = 8'hF0; inp2 = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        drain(40);
        cmp("stat_sat", {16'b0, stat_beats}, 32'hFFFF);
`else
        cmp("stat_off", {16'b0, stat_beats}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
